// File: rtl/cw_stream_gen.sv
// DFT codebook streamer: beats of LANES samples of w(k,n)=exp(+j*2*pi*k*n/DEPTH) over valid/ready.
// Optional feature macro CW_CONJ_EN adds i_conj, which selects the conjugate codeword (Q=-SIN).
module cw_stream_gen #(
  parameter int unsigned ANTS  = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IQW   = 16,
  parameter int unsigned LANES = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_start,
  input  logic [1:0]               i_mode,
`ifdef CW_CONJ_EN
  input  logic                     i_conj,
`endif
  input  logic                     i_tready,
  output logic                     o_tvalid,
  output logic [LANES*2*IQW-1:0]   o_tdata,
  output logic                     o_tlast,
  output logic                     o_sof,
  output logic                     o_eof,
  output logic [$clog2(DEPTH)-1:0] o_beam_idx,
  output logic                     o_busy
);

  localparam int unsigned G     = ANTS / LANES;
  localparam int unsigned KW    = $clog2(DEPTH);
  localparam int unsigned GW    = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned DW    = LANES * 2 * IQW;
  localparam logic [GW-1:0] GLast = GW'(G - 1);
  localparam real Pi  = 3.141592653589793;
  localparam real Amp = real'((64'd1 << (IQW - 1)) - 64'd1);

  typedef enum logic {StIdle, StRun} state_e;

  // Quarter-free full-period tables; amplitude 2^(IQW-1)-1 keeps negation overflow-safe.
  logic signed [IQW-1:0] cos_lut [DEPTH];
  logic signed [IQW-1:0] sin_lut [DEPTH];

  for (genvar p = 0; p < DEPTH; p++) begin : g_lut
    localparam real CosR = Amp * $cos(2.0 * Pi * real'(p) / real'(DEPTH));
    localparam real SinR = Amp * $sin(2.0 * Pi * real'(p) / real'(DEPTH));
    localparam int  CosI = (CosR >= 0.0) ? $rtoi(CosR + 0.5) : -$rtoi(0.5 - CosR);
    localparam int  SinI = (SinR >= 0.0) ? $rtoi(SinR + 0.5) : -$rtoi(0.5 - SinR);
    assign cos_lut[p] = IQW'(CosI);
    assign sin_lut[p] = IQW'(SinI);
  end

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic          conj_q, conj_d, conj_in;
  logic [KW-1:0] k_q, k_d, k_step, k_last;
  logic [GW-1:0] g_q, g_d;
  logic          load, clear;
  logic          tlast_n, eof_n;
  logic          tvalid_q, tlast_q, sof_q, eof_q, busy_q;
  logic [DW-1:0] tdata_q, beat_data;
  logic [KW-1:0] n_mod, phase;
  logic signed [IQW-1:0] q_val;

`ifdef CW_CONJ_EN
  assign conj_in = i_conj;
`else
  assign conj_in = 1'b0;
`endif

  // Even/odd beam sets step by two; mode 3 was folded to 0 when latched.
  assign k_step = (mode_q == 2'd0) ? KW'(1) : KW'(2);
  assign k_last = (mode_d == 2'd1) ? KW'(DEPTH - 2) : KW'(DEPTH - 1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    conj_d  = conj_q;
    k_d     = k_q;
    g_d     = g_q;
    load    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start && i_enable) begin
          state_d = StRun;
          mode_d  = (i_mode == 2'd3) ? 2'd0 : i_mode;
          conj_d  = conj_in;
          k_d     = (i_mode == 2'd2) ? KW'(1) : '0;
          g_d     = '0;
          load    = 1'b1;
        end
      end
      StRun: begin
        // o_tvalid is always high in StRun, so i_tready alone marks a transfer.
        if (!i_enable || (i_tready && eof_q)) begin
          state_d = StIdle;
          k_d     = '0;
          g_d     = '0;
          clear   = 1'b1;
        end else if (i_tready) begin
          load = 1'b1;
          if (g_q == GLast) begin
            g_d = '0;
            k_d = k_q + k_step;
          end else begin
            g_d = g_q + GW'(1);
          end
        end
      end
    endcase
  end

  assign tlast_n = (g_d == GLast);
  assign eof_n   = tlast_n && (k_d == k_last);

  // Phase is (k*n) mod DEPTH: KW-bit product keeps only the low bits.
  always_comb begin
    beat_data = '0;
    n_mod     = '0;
    phase     = '0;
    q_val     = '0;
    for (int l = 0; l < LANES; l++) begin
      n_mod = KW'(int'(g_d) * int'(LANES) + l);
      phase = k_d * n_mod;
      q_val = conj_d ? -sin_lut[phase] : sin_lut[phase];
      beat_data[l*2*IQW +: 2*IQW] = {q_val, cos_lut[phase]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      mode_q   <= 2'd0;
      conj_q   <= 1'b0;
      k_q      <= '0;
      g_q      <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      busy_q   <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      conj_q  <= conj_d;
      k_q     <= k_d;
      g_q     <= g_d;
      if (clear) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        sof_q    <= 1'b0;
        eof_q    <= 1'b0;
        busy_q   <= 1'b0;
        tdata_q  <= '0;
      end else if (load) begin
        tvalid_q <= 1'b1;
        tlast_q  <= tlast_n;
        sof_q    <= (state_q == StIdle);
        eof_q    <= eof_n;
        busy_q   <= 1'b1;
        tdata_q  <= beat_data;
      end
    end
  end

  assign o_tvalid   = tvalid_q;
  assign o_tdata    = tdata_q;
  assign o_tlast    = tlast_q;
  assign o_sof      = sof_q;
  assign o_eof      = eof_q;
  assign o_beam_idx = k_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_cw_stream_gen.sv
// Bench for cw_stream_gen: randomized handshake against a real-arithmetic codebook model.
// Build with CW_CONJ_EN defined to also exercise the conjugate codeword path.
module tb_cw_stream_gen;

  localparam int ANTS  = 32;
  localparam int DEPTH = 64;
  localparam int IQW   = 16;
  localparam int LANES = 8;
  localparam int G     = ANTS / LANES;
  localparam int DW    = LANES * 2 * IQW;
  localparam int KW    = $clog2(DEPTH);
  localparam int SW    = 1 + KW + 3 + DW;
  localparam int AMP   = (1 << (IQW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic start = 1'b0;
  logic tready = 1'b0;
  logic [1:0] mode = 2'd0;
`ifdef CW_CONJ_EN
  logic conj = 1'b0;
`endif
  logic tvalid, tlast, sof, eof, busy;
  logic [DW-1:0] tdata;
  logic [KW-1:0] beam;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int k;
    int g;
    bit last;
    bit sof;
    bit eof;
    logic [DW-1:0] d;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  cw_stream_gen #(
    .ANTS (ANTS),
    .DEPTH(DEPTH),
    .IQW  (IQW),
    .LANES(LANES)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_enable  (en),
    .i_start   (start),
    .i_mode    (mode),
`ifdef CW_CONJ_EN
    .i_conj    (conj),
`endif
    .i_tready  (tready),
    .o_tvalid  (tvalid),
    .o_tdata   (tdata),
    .o_tlast   (tlast),
    .o_sof     (sof),
    .o_eof     (eof),
    .o_beam_idx(beam),
    .o_busy    (busy)
  );

  function automatic int lutv(int p, bit want_sin);
    real a, v;
    a = 2.0 * 3.141592653589793 * real'(p) / real'(DEPTH);
    v = real'(AMP) * (want_sin ? $sin(a) : $cos(a));
    return $rtoi($floor(v + 0.5));
  endfunction

  // Golden sweep: beam list from the mode rule, phase by plain modulo arithmetic.
  task automatic build_model(input int md, input bit cj);
    beat_t b;
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      if ((md == 1 && k % 2 != 0) || (md == 2 && k % 2 == 0)) continue;
      for (int g = 0; g < G; g++) begin
        b.k = k;
        b.g = g;
        b.last = (g == G - 1);
        b.sof = (exp_q.size() == 0);
        b.eof = 1'b0;
        b.d = '0;
        for (int l = 0; l < LANES; l++) begin
          int p;
          int iv;
          int qv;
          p  = (k * (g * LANES + l)) % DEPTH;
          iv = lutv(p, 1'b0);
          qv = cj ? -lutv(p, 1'b1) : lutv(p, 1'b1);
          b.d[l*2*IQW +: IQW]       = iv[IQW-1:0];
          b.d[l*2*IQW + IQW +: IQW] = qv[IQW-1:0];
        end
        exp_q.push_back(b);
      end
    end
    b = exp_q.pop_back();
    b.eof = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b1; tready = 1'b1; mode = 2'd0;
    repeat (3) step();
    rst = 1'b0; start = 1'b0;
    n_cmp++;
    if ({tvalid, busy, tlast, sof, eof, beam, tdata} !== '0) begin
      n_err++;
      $display("FAIL reset_out: got v=%b b=%b d=%h required all 0", tvalid, busy, tdata);
    end
    repeat (4) begin
      step();
      n_cmp++;
      if (tvalid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_no_beat: got v=%b b=%b required 0 0", tvalid, busy);
      end
    end
    en = 1'b0; start = 1'b1;
    step();
    start = 1'b0; en = 1'b1;
    step();
    n_cmp++;
    if (tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL start_disabled: got v=%b required 0", tvalid);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({tvalid, busy, tlast, sof, eof, beam, tdata} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b b=%b k=%0d d=%h required all 0", tvalid, busy, beam, tdata);
    end
  endtask

  task automatic test_mode0();
    int idx = 0;
    int cyc = 0;
    logic [SW-1:0] snap, want;
    beat_t e;
    build_model(0, 1'b0);
    mode = 2'd0; en = 1'b1; tready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    while (idx < exp_q.size() && cyc < 1000) begin
      snap = {tvalid, beam, tlast, sof, eof, tdata};
      e = exp_q[idx];
      want = {1'b1, KW'(e.k), e.last, e.sof, e.eof, e.d};
      n_cmp++;
      if (snap !== want) begin
        n_err++;
        $display("FAIL m0_beat[%0d]: got %h required %h", idx, snap, want);
      end
      if (idx == 0) begin
        n_cmp++;
        if (tdata !== {LANES{16'h0000, 16'h7fff}}) begin
          n_err++;
          $display("FAIL m0_beam0: got %h required I=7fff Q=0 all lanes", tdata);
        end
      end
      if (idx == 255) begin
        n_cmp++;
        if (beam !== KW'(63) || eof !== 1'b1 || tlast !== 1'b1) begin
          n_err++;
          $display("FAIL m0_last: got k=%0d eof=%b last=%b required 63 1 1", beam, eof, tlast);
        end
      end
      if (!tvalid) break;
      idx++;
      step();
      cyc++;
    end
    n_cmp++;
    if (idx != 256 || cyc != 256) begin
      n_err++;
      $display("FAIL m0_count: got %0d beats in %0d cycles required 256 in 256", idx, cyc);
    end
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL m0_done: got v=%b b=%b required 0 0", tvalid, busy);
    end
  endtask

  task automatic test_mode1();
    int idx = 0;
    int cyc = 0;
    logic [SW-1:0] snap, want;
    beat_t e;
    build_model(1, 1'b0);
    mode = 2'd1; en = 1'b1; tready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    while (idx < exp_q.size() && cyc < 1000) begin
      if (!tvalid) break;
      snap = {tvalid, beam, tlast, sof, eof, tdata};
      e = exp_q[idx];
      want = {1'b1, KW'(e.k), e.last, e.sof, e.eof, e.d};
      n_cmp++;
      if (snap !== want) begin
        n_err++;
        $display("FAIL m1_beat[%0d]: got %h required %h", idx, snap, want);
      end
      if (e.k == 2 && e.g == 2) begin
        n_cmp++;
        if (tdata[2*IQW-1:0] !== 32'h0000_8001) begin
          n_err++;
          $display("FAIL m1_k2_n16: got %h required Q=0000 I=8001", tdata[2*IQW-1:0]);
        end
      end
      if (e.k == 16 && e.g == 0) begin
        n_cmp++;
        if (tdata[2*IQW +: 2*IQW] !== 32'h7fff_0000) begin
          n_err++;
          $display("FAIL m1_k16_n1: got %h required Q=7fff I=0000", tdata[2*IQW +: 2*IQW]);
        end
      end
      // A start pulse on the edge that accepts the final beat must not restart.
      start = (idx == exp_q.size() - 1);
      idx++;
      step();
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (idx != 128 || tvalid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL m1_end: got %0d beats v=%b b=%b required 128 0 0", idx, tvalid, busy);
    end
    step();
    n_cmp++;
    if (tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL m1_start_at_eof: got v=%b required 0", tvalid);
    end
  endtask

  task automatic test_mode2_stall();
    int idx = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [SW-1:0] snap, prev, want;
    beat_t e;
    build_model(2, 1'b0);
    mode = 2'd2; en = 1'b1; tready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    prev = '0;
    while (idx < exp_q.size() && cyc < 5000) begin
      snap = {tvalid, beam, tlast, sof, eof, tdata};
      if (prev_stall) begin
        n_cmp++;
        if (snap !== prev) begin
          n_err++;
          $display("FAIL m2_hold[%0d]: got %h required %h", idx, snap, prev);
        end
      end
      mode = 2'($urandom_range(0, 3));
      tready = 1'($urandom_range(0, 1));
      if (tvalid && tready) begin
        e = exp_q[idx];
        want = {1'b1, KW'(e.k), e.last, e.sof, e.eof, e.d};
        n_cmp++;
        if (snap !== want) begin
          n_err++;
          $display("FAIL m2_beat[%0d]: got %h required %h", idx, snap, want);
        end
        idx++;
      end
      prev_stall = tvalid && !tready;
      prev = snap;
      step();
      cyc++;
    end
    n_cmp++;
    if (idx != 128 || tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL m2_count: got %0d beats v=%b required 128 0", idx, tvalid);
    end
    tready = 1'b1;
  endtask

  task automatic test_abort_restart();
    int idx = 0;
    int cyc = 0;
    logic [SW-1:0] snap, want;
    beat_t e;
    build_model(0, 1'b0);
    mode = 2'd0; en = 1'b1; tready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    while (idx < 100 && cyc < 500) begin
      if (!tvalid) break;
      snap = {tvalid, beam, tlast, sof, eof, tdata};
      e = exp_q[idx];
      want = {1'b1, KW'(e.k), e.last, e.sof, e.eof, e.d};
      n_cmp++;
      if (snap !== want) begin
        n_err++;
        $display("FAIL ab_beat[%0d]: got %h required %h", idx, snap, want);
      end
      start = (idx == 50);
      idx++;
      step();
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (idx != 100 || tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL ab_progress: got %0d beats v=%b required 100 1", idx, tvalid);
    end
    en = 1'b0;
    step();
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || tdata !== '0) begin
      n_err++;
      $display("FAIL ab_abort: got v=%b b=%b d=%h required 0 0 0", tvalid, busy, tdata);
    end
    // Restart with mode 3, which must behave as mode 0.
    en = 1'b1; mode = 2'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      snap = {tvalid, beam, tlast, sof, eof, tdata};
      e = exp_q[i];
      want = {1'b1, KW'(e.k), e.last, e.sof, e.eof, e.d};
      n_cmp++;
      if (snap !== want) begin
        n_err++;
        $display("FAIL ab_restart[%0d]: got %h required %h", i, snap, want);
      end
      step();
    end
    en = 1'b0;
    step();
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ab_abort2: got v=%b b=%b required 0 0", tvalid, busy);
    end
    en = 1'b1;
  endtask

`ifdef CW_CONJ_EN
  task automatic test_conj();
    int idx = 0;
    int cyc = 0;
    logic [SW-1:0] snap, want;
    beat_t e;
    build_model(0, 1'b1);
    mode = 2'd0; en = 1'b1; tready = 1'b1; conj = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    conj = 1'b0;
    while (idx < exp_q.size() && cyc < 1000) begin
      if (!tvalid) break;
      snap = {tvalid, beam, tlast, sof, eof, tdata};
      e = exp_q[idx];
      want = {1'b1, KW'(e.k), e.last, e.sof, e.eof, e.d};
      n_cmp++;
      if (snap !== want) begin
        n_err++;
        $display("FAIL cj_beat[%0d]: got %h required %h", idx, snap, want);
      end
      if (e.k == 16 && e.g == 0) begin
        n_cmp++;
        if (tdata[2*IQW +: 2*IQW] !== 32'h8001_0000) begin
          n_err++;
          $display("FAIL cj_k16_n1: got %h required Q=8001 I=0000", tdata[2*IQW +: 2*IQW]);
        end
      end
      idx++;
      step();
      cyc++;
    end
    n_cmp++;
    if (idx != 256 || tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL cj_count: got %0d beats v=%b required 256 0", idx, tvalid);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_mode2_stall();
    test_abort_restart();
`ifdef CW_CONJ_EN
    test_conj();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
